// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-port arbiter in front of the single external memory bus.
// Ownership is locked from the first request cycle until memory returns
// ready, so a transfer in flight is never pre-empted. Arbitration in IDLE is
// combinational (fixed priority or round-robin), giving zero added latency.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | no transfer locked; winner picked combinationally from valids
//  LOCKED | transfer in flight; mem bus driven by owner until ready
module mem_arbiter_rr #(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MODE    = 0
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic [N_PORTS-1:0]          req_valid_i,
    input  logic [N_PORTS-1:0]          req_write_i,
    input  logic [N_PORTS*ADDR_W-1:0]   req_addr_i,
    input  logic [N_PORTS*DATA_W-1:0]   req_wr_data_i,
    output logic [N_PORTS-1:0]          req_ready_o,
    output logic [N_PORTS*DATA_W-1:0]   req_rd_data_o,
    output logic                        mem_valid_o,
    output logic                        mem_write_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [DATA_W-1:0]           mem_wr_data_o,
    input  logic [DATA_W-1:0]           mem_rd_data_i,
    input  logic                        mem_ready_i,
    output logic [N_PORTS-1:0]          grant_o,
    output logic                        busy_o
);

    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [IDX_W:0]   N_W  = (IDX_W+1)'(N_PORTS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_PORTS - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;

    logic [IDX_W-1:0]     base;
    logic [2*N_PORTS-1:0] rot_full;
    logic [N_PORTS-1:0]   rot;
    logic [IDX_W:0]       sum;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic                 owner_valid;
    logic [IDX_W-1:0]     sel;
    logic                 active;

    // Search the valids starting at the priority base (0 or rr_ptr), wrapping.
    always_comb begin
        base      = (MODE == 1) ? rr_ptr : '0;
        rot_full  = {req_valid_i, req_valid_i} >> base;
        rot       = rot_full[N_PORTS-1:0];
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (!win_found && rot[i]) begin
                win_found = 1'b1;
                sum       = {1'b0, base} + (IDX_W+1)'(i);
                if (sum >= N_W) begin
                    sum = sum - N_W;
                end
                win_idx = sum[IDX_W-1:0];
            end
        end
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state  <= S_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Next-state logic and mem/requester side muxing; everything reads 0 in reset.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        owner_valid   = 1'b0;
        sel           = '0;
        active        = 1'b0;
        mem_valid_o   = 1'b0;
        mem_write_o   = 1'b0;
        mem_addr_o    = '0;
        mem_wr_data_o = '0;
        grant_o       = '0;
        req_ready_o   = '0;

        for (int k = 0; k < N_PORTS; k++) begin
            if (owner == IDX_W'(k)) begin
                owner_valid = req_valid_i[k];
            end
        end

        case (state)
            S_IDLE: begin
                sel    = win_idx;
                active = win_found & reset_ni;
                if (active && !mem_ready_i) begin
                    state_nxt = S_LOCKED;
                    owner_nxt = win_idx;
                end
            end
            S_LOCKED: begin
                sel    = owner;
                active = owner_valid & reset_ni;
                // Owner dropping valid early is a protocol error: release the bus.
                if (!active || mem_ready_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if ((MODE == 1) && active && mem_ready_i) begin
            rr_ptr_nxt = (sel == LAST) ? '0 : sel + IDX_W'(1);
        end

        mem_valid_o = active;
        for (int k = 0; k < N_PORTS; k++) begin
            if (active && (sel == IDX_W'(k))) begin
                mem_write_o    = req_write_i[k];
                mem_addr_o     = req_addr_i[k*ADDR_W +: ADDR_W];
                mem_wr_data_o  = req_wr_data_i[k*DATA_W +: DATA_W];
                grant_o[k]     = 1'b1;
                req_ready_o[k] = mem_ready_i;
            end
        end
    end

    assign req_rd_data_o = reset_ni ? {N_PORTS{mem_rd_data_i}} : '0;
    assign busy_o        = (state == S_LOCKED);

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: a 2-port fixed-priority instance driven from a
// vector table and a 4-port round-robin instance driven by a reference model.
module tb_mem_arbiter_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [1:0]   fp_valid, fp_write, fp_ready, fp_grant;
    logic [63:0]  fp_addr, fp_wdata, fp_rdata;
    logic         fp_mvalid, fp_mwrite, fp_mready, fp_busy;
    logic [31:0]  fp_maddr, fp_mwdata, fp_mrdata;

    logic [3:0]   rr_valid, rr_write, rr_ready, rr_grant;
    logic [127:0] rr_addr, rr_wdata, rr_rdata;
    logic         rr_mvalid, rr_mwrite, rr_mready, rr_busy;
    logic [31:0]  rr_maddr, rr_mwdata, rr_mrdata;

    mem_arbiter_rr #(.N_PORTS(2), .ADDR_W(32), .DATA_W(32), .MODE(0)) u_fp (
        .clk_i(clk), .reset_ni(rst_n),
        .req_valid_i(fp_valid), .req_write_i(fp_write),
        .req_addr_i(fp_addr), .req_wr_data_i(fp_wdata),
        .req_ready_o(fp_ready), .req_rd_data_o(fp_rdata),
        .mem_valid_o(fp_mvalid), .mem_write_o(fp_mwrite),
        .mem_addr_o(fp_maddr), .mem_wr_data_o(fp_mwdata),
        .mem_rd_data_i(fp_mrdata), .mem_ready_i(fp_mready),
        .grant_o(fp_grant), .busy_o(fp_busy)
    );

    mem_arbiter_rr #(.N_PORTS(4), .ADDR_W(32), .DATA_W(32), .MODE(1)) u_rr (
        .clk_i(clk), .reset_ni(rst_n),
        .req_valid_i(rr_valid), .req_write_i(rr_write),
        .req_addr_i(rr_addr), .req_wr_data_i(rr_wdata),
        .req_ready_o(rr_ready), .req_rd_data_o(rr_rdata),
        .mem_valid_o(rr_mvalid), .mem_write_o(rr_mwrite),
        .mem_addr_o(rr_maddr), .mem_wr_data_o(rr_mwdata),
        .mem_rd_data_i(rr_mrdata), .mem_ready_i(rr_mready),
        .grant_o(rr_grant), .busy_o(rr_busy)
    );

    typedef struct {
        string       name;
        logic        mvalid;
        logic        mwrite;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  grant;
        logic [3:0]  ready;
        logic        busy;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  write;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        mready;
        logic [31:0] mrdata;
        exp_t        exp;
    } vec_t;

    localparam logic [31:0] W0 = 32'hA0A0_0000;
    localparam logic [31:0] W1 = 32'hB1B1_0000;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[18];
    logic [1:0] mptr;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [1:0] v, input logic [1:0] w,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic mr, input logic [31:0] rd,
                                input logic ev, input logic ew, input logic [31:0] ea,
                                input logic [31:0] ewd, input logic [1:0] eg,
                                input logic [1:0] er, input logic eb);
        vec_t t;
        t.valid = v; t.write = w; t.a0 = a0; t.a1 = a1; t.mready = mr; t.mrdata = rd;
        t.exp.name = n; t.exp.mvalid = ev; t.exp.mwrite = ew; t.exp.addr = ea;
        t.exp.wdata = ewd; t.exp.grant = {2'b00, eg}; t.exp.ready = {2'b00, er};
        t.exp.busy = eb; t.exp.rd = rd;
        return t;
    endfunction

    task automatic pop_check_fp();
        exp_t e;
        if (sb.size() == 0) begin
            chk("fp_scoreboard_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({e.name, " mvalid"}, fp_mvalid, e.mvalid);
        chk({e.name, " mwrite"}, fp_mwrite, e.mwrite);
        chk({e.name, " addr"},   fp_maddr,  e.addr);
        chk({e.name, " wdata"},  fp_mwdata, e.wdata);
        chk({e.name, " grant"},  fp_grant,  e.grant[1:0]);
        chk({e.name, " ready"},  fp_ready,  e.ready[1:0]);
        chk({e.name, " busy"},   fp_busy,   e.busy);
        if (e.ready != 0) begin
            chk({e.name, " rd0"}, fp_rdata[31:0],  e.rd);
            chk({e.name, " rd1"}, fp_rdata[63:32], e.rd);
        end
    endtask

    // Single-cycle transfers on the round-robin instance, checked against a pointer model.
    task automatic rr_cycle(input logic [3:0] v, input string name);
        exp_t e;
        int   w;
        w = -1;
        for (int i = 0; i < 4; i++) begin
            int idx;
            idx = (int'(mptr) + i) % 4;
            if (w < 0 && v[idx]) w = idx;
        end
        rr_valid  = v;
        rr_mready = 1'b1;
        e.name = name; e.mwrite = 1'b0; e.wdata = 32'h0; e.busy = 1'b0; e.rd = rr_mrdata;
        if (w >= 0) begin
            e.mvalid = 1'b1;
            e.addr   = 32'h4000 + 32'(w) * 32'h10;
            e.grant  = 4'b0001 << w;
            e.ready  = 4'b0001 << w;
        end else begin
            e.mvalid = 1'b0; e.addr = 32'h0; e.grant = 4'h0; e.ready = 4'h0;
        end
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        chk({e.name, " mvalid"}, rr_mvalid, e.mvalid);
        chk({e.name, " addr"},   rr_maddr,  e.addr);
        chk({e.name, " grant"},  rr_grant,  e.grant);
        chk({e.name, " ready"},  rr_ready,  e.ready);
        chk({e.name, " busy"},   rr_busy,   e.busy);
        if (w >= 0) mptr = 2'((w + 1) % 4);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        fp_valid  = 2'b11; fp_write = 2'b00; fp_addr = {32'h2000, 32'h1000};
        fp_wdata  = {W1, W0}; fp_mready = 1'b1; fp_mrdata = 32'hFFFF_FFFF;
        rr_valid  = 4'h0; rr_write = 4'h0; rr_wdata = '0; rr_mready = 1'b0;
        rr_mrdata = 32'hCAFE_F00D;
        rr_addr   = {32'h4030, 32'h4020, 32'h4010, 32'h4000};
        mptr      = 2'd0;

        vecs[0]  = mk("fp_col_c0",   2'b11, 2'b00, 32'h1000, 32'h2000, 0, 32'h0,        1, 0, 32'h1000, W0, 2'b01, 2'b00, 0);
        vecs[1]  = mk("fp_col_c1",   2'b11, 2'b00, 32'h1000, 32'h2000, 0, 32'h0,        1, 0, 32'h1000, W0, 2'b01, 2'b00, 1);
        vecs[2]  = mk("fp_col_c2",   2'b11, 2'b00, 32'h1000, 32'h2000, 0, 32'h0,        1, 0, 32'h1000, W0, 2'b01, 2'b00, 1);
        vecs[3]  = mk("fp_col_rdy",  2'b11, 2'b00, 32'h1000, 32'h2000, 1, 32'h1234_5678, 1, 0, 32'h1000, W0, 2'b01, 2'b01, 1);
        vecs[4]  = mk("fp_col_p1",   2'b10, 2'b00, 32'h1000, 32'h2000, 0, 32'h0,        1, 0, 32'h2000, W1, 2'b10, 2'b00, 0);
        vecs[5]  = mk("fp_col_p1rdy",2'b10, 2'b00, 32'h1000, 32'h2000, 1, 32'h0000_BEEF, 1, 0, 32'h2000, W1, 2'b10, 2'b10, 1);
        vecs[6]  = mk("fp_idle",     2'b00, 2'b00, 32'h1000, 32'h2000, 0, 32'h0,        0, 0, 32'h0,    0,  2'b00, 2'b00, 0);
        vecs[7]  = mk("np_start",    2'b10, 2'b00, 32'h3000, 32'h0100, 0, 32'h0,        1, 0, 32'h0100, W1, 2'b10, 2'b00, 0);
        vecs[8]  = mk("np_hold",     2'b11, 2'b00, 32'h3000, 32'h0100, 0, 32'h0,        1, 0, 32'h0100, W1, 2'b10, 2'b00, 1);
        vecs[9]  = mk("np_rdy",      2'b11, 2'b00, 32'h3000, 32'h0100, 1, 32'h0000_0100, 1, 0, 32'h0100, W1, 2'b10, 2'b10, 1);
        vecs[10] = mk("np_next",     2'b01, 2'b00, 32'h3000, 32'h0100, 1, 32'h55AA_55AA, 1, 0, 32'h3000, W0, 2'b01, 2'b01, 0);
        vecs[11] = mk("zl_read",     2'b10, 2'b00, 32'h3000, 32'h0044, 1, 32'hDEAD_BEEF, 1, 0, 32'h0044, W1, 2'b10, 2'b10, 0);
        vecs[12] = mk("zl_after",    2'b00, 2'b00, 32'h3000, 32'h0044, 0, 32'h0,        0, 0, 32'h0,    0,  2'b00, 2'b00, 0);
        vecs[13] = mk("drop_start",  2'b01, 2'b01, 32'h0500, 32'h2000, 0, 32'h0,        1, 1, 32'h0500, W0, 2'b01, 2'b00, 0);
        vecs[14] = mk("drop_cycle",  2'b10, 2'b00, 32'h0500, 32'h2000, 1, 32'h0,        0, 0, 32'h0,    0,  2'b00, 2'b00, 1);
        vecs[15] = mk("drop_idle",   2'b10, 2'b00, 32'h0500, 32'h2000, 0, 32'h0,        1, 0, 32'h2000, W1, 2'b10, 2'b00, 0);
        vecs[16] = mk("drop_p1rdy",  2'b10, 2'b00, 32'h0500, 32'h2000, 1, 32'h7777_0001, 1, 0, 32'h2000, W1, 2'b10, 2'b10, 1);
        vecs[17] = mk("end_idle",    2'b00, 2'b00, 32'h0500, 32'h2000, 1, 32'h0,        0, 0, 32'h0,    0,  2'b00, 2'b00, 0);

        // Reset forces all outputs low even with valid and ready asserted.
        #2;
        chk("rst mvalid", fp_mvalid, 0);
        chk("rst addr",   fp_maddr,  0);
        chk("rst grant",  fp_grant,  0);
        chk("rst ready",  fp_ready,  0);
        chk("rst rdata",  fp_rdata,  0);
        chk("rst busy",   fp_busy,   0);
        @(negedge clk);
        rst_n = 1'b1;
        fp_valid = 2'b00; fp_mready = 1'b0;

        for (int i = 0; i < 18; i++) begin
            fp_valid  = vecs[i].valid;
            fp_write  = vecs[i].write;
            fp_addr   = {vecs[i].a1, vecs[i].a0};
            fp_mready = vecs[i].mready;
            fp_mrdata = vecs[i].mrdata;
            sb.push_back(vecs[i].exp);
            #2;
            pop_check_fp();
            @(negedge clk);
        end
        fp_valid = 2'b00; fp_mready = 1'b0;

        // Round-robin rotation with all ports requesting: 0,1,2,3,0,1.
        for (int i = 0; i < 6; i++) rr_cycle(4'b1111, $sformatf("rr_rot%0d", i));
        for (int i = 0; i < 16; i++) rr_cycle(4'($urandom_range(0, 15)), $sformatf("rr_rand%0d", i));
        rr_cycle(4'b0010, "rr_p1");
        chk("rr_model_ptr", mptr, 2);

        // Lock port 2 (pointer now 2), then reset mid-transfer.
        rr_valid = 4'b0100; rr_mready = 1'b0;
        #2;
        chk("rr_lock grant", rr_grant, 4'b0100);
        chk("rr_lock addr",  rr_maddr, 32'h4020);
        @(negedge clk);
        rr_valid = 4'b0110;
        #2;
        chk("rr_locked busy",  rr_busy,  1);
        chk("rr_locked grant", rr_grant, 4'b0100);
        chk("rr_locked addr",  rr_maddr, 32'h4020);
        rr_mready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rr_async mvalid", rr_mvalid, 0);
        chk("rr_async addr",   rr_maddr,  0);
        chk("rr_async grant",  rr_grant,  0);
        chk("rr_async ready",  rr_ready,  0);
        chk("rr_async rdata",  rr_rdata,  0);
        chk("rr_async busy",   rr_busy,   0);
        @(negedge clk);
        rst_n = 1'b1; rr_mready = 1'b0;
        #2;
        chk("rr_post grant", rr_grant, 4'b0010);
        chk("rr_post addr",  rr_maddr, 32'h4010);
        chk("rr_post busy",  rr_busy,  0);
        @(negedge clk);
        rr_mready = 1'b1;
        #2;
        chk("rr_post ready", rr_ready, 4'b0010);
        chk("rr_post rd",    rr_rdata[63:32], 32'hCAFE_F00D);
        @(negedge clk);
        rr_valid = 4'h0; rr_mready = 1'b0;
        repeat (2) @(negedge clk);

        chk("scoreboard drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
